// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid buffer pipeline register with flush.
// Define PIPE_STAGE_KEEP_PC_EN to keep OutPC through Flush for EPC reporting.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [PC_W-1:0]   InPC,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [PC_W-1:0]   OutPC,
  output logic [1:0]        Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_head_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_head_pc;
  logic [PC_W-1:0]   r_skid_pc;
  logic [DATA_W-1:0] w_head_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [PC_W-1:0]   w_head_pc_nxt;
  logic [PC_W-1:0]   w_skid_pc_nxt;
  logic              w_out_valid;
  logic              w_in;
  logic              w_out;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in        = InValid && r_in_ready;
  assign w_out       = w_out_valid && OutReady;

  always_comb begin
    w_next_state    = r_state;
    w_head_data_nxt = r_head_data;
    w_head_pc_nxt   = r_head_pc;
    w_skid_data_nxt = r_skid_data;
    w_skid_pc_nxt   = r_skid_pc;
    if (Flush) begin
      w_next_state    = EMPTY;
      w_head_data_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_pc_nxt   = '0;
`ifdef PIPE_STAGE_KEEP_PC_EN
      w_head_pc_nxt   = r_head_pc;
`else
      w_head_pc_nxt   = '0;
`endif
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in) begin
            w_next_state    = ONE;
            w_head_data_nxt = InData;
            w_head_pc_nxt   = InPC;
          end
        end
        ONE: begin
          if (w_in && w_out) begin
            w_head_data_nxt = InData;
            w_head_pc_nxt   = InPC;
          end else if (w_in) begin
            w_next_state    = TWO;
            w_skid_data_nxt = InData;
            w_skid_pc_nxt   = InPC;
          end else if (w_out) begin
            w_next_state    = EMPTY;
            w_head_data_nxt = '0;
            w_head_pc_nxt   = '0;
          end
        end
        TWO: begin
          // InReady is low here, so only the drain direction can move.
          if (w_out) begin
            w_next_state    = ONE;
            w_head_data_nxt = r_skid_data;
            w_head_pc_nxt   = r_skid_pc;
            w_skid_data_nxt = '0;
            w_skid_pc_nxt   = '0;
          end
        end
        default: begin
          w_next_state = EMPTY;
        end
      endcase
    end
  end

  // InReady is registered from the next state so OutReady never reaches it combinationally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_skid_data <= '0;
      r_skid_pc   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != TWO);
      r_head_data <= w_head_data_nxt;
      r_head_pc   <= w_head_pc_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = w_out_valid;
  assign OutData  = w_out_valid ? r_head_data : '0;
  assign OutPC    = r_head_pc;
  assign Count    = r_state;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning payload width in bits (Instr, ALUOut, RD2, A3, WD packed by the instantiating stage).
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the carried PC field.
REQ-003 SHALL have port Clk  input  1  clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset  input  1  reset (synchronous, active-high).
REQ-005 SHALL have port Flush  input  1  synchronous squash of all held entries.
REQ-006 SHALL have port InValid  input  1  upstream offers InData/InPC this cycle.
REQ-007 SHALL have port InReady  output  1  stage accepts an offer this cycle; driven directly from a register.
REQ-008 SHALL have port InData  input  DATA_W  upstream payload.
REQ-009 SHALL have port InPC  input  PC_W  upstream PC.
REQ-010 SHALL have port OutValid  output  1  OutData/OutPC hold a live entry.
REQ-011 SHALL have port OutReady  input  1  downstream consumes the head entry this cycle.
REQ-012 SHALL have port OutData  output  DATA_W  head entry payload.
REQ-013 SHALL have port OutPC  output  PC_W  head entry PC.
REQ-014 SHALL have port Count  output  2  number of held entries (0..2).

Function
REQ-015 SHALL be a 2-entry skid buffer: a head register (drives Out*) and a skid register; in = InValid&&InReady, out = OutValid&&OutReady.
REQ-016 SHALL implement states EMPTY (Count=0), ONE (Count=1, head live), TWO (Count=2, head and skid live).
REQ-017 SHALL transition EMPTY->ONE on in, with the offer loaded into head.
REQ-018 SHALL, in ONE: in&&out -> ONE with head replaced by the offer; in&&!out -> TWO with the offer in skid; !in&&out -> EMPTY; otherwise hold.
REQ-019 SHALL, in TWO: out -> ONE with skid moved to head; otherwise hold; InReady=0, so in is impossible.
REQ-020 SHALL drive InReady=1 exactly when the registered state is not TWO, with zero combinational path from OutReady to InReady.
REQ-021 SHALL deliver entries in order, without loss or duplication; latency is 1 cycle from in to OutValid when the stage is EMPTY.
REQ-022 SHALL hold OutData/OutPC stable while OutValid=1 and OutReady=0.
REQ-023 SHALL, on Flush=1, enter EMPTY at the next edge and zero head and skid data; Flush takes priority over a simultaneous in or out, and the simultaneous offer is dropped.
REQ-024 SHALL drive OutData=0 whenever OutValid=0 (bubble equals all-zero instruction, nop).
REQ-025 SHALL keep the state unchanged when an offer is made with InReady=0; the offer is ignored.

Reset
REQ-026 SHALL, on Reset=1 at posedge Clk, set state EMPTY, OutValid=0, Count=0, InReady=1, OutData=0, OutPC=0, skid=0.
REQ-027 SHALL give Reset priority over Flush, in, and out, including mid-operation in state TWO.
REQ-028 SHALL have all outputs defined from the first edge after Reset with no X on Out*.

Configuration
REQ-029 SHALL, with macro PIPE_STAGE_KEEP_PC_EN defined, leave OutPC holding its pre-flush value on Flush (data still zeroed), so the bubble carries the victim PC for EPC reporting.
REQ-030 SHALL, without PIPE_STAGE_KEEP_PC_EN, zero OutPC on Flush along with OutData.
REQ-031 SHALL zero OutPC on Reset regardless of PIPE_STAGE_KEEP_PC_EN.

Verification
REQ-032 SHALL cover streaming: OutReady=1, offers 0x11/PC 0x3000, then 0x22/0x3004 on consecutive cycles -> Out shows 0x11 then 0x22 one cycle later each; Count stays 1; InReady stays 1.
REQ-033 SHALL cover backpressure: OutReady=0, three offers A, B, C -> A and B accepted, Count=2, InReady=0, C held upstream; then OutReady=1 -> outputs A, B, C in order.
REQ-034 SHALL cover flush in TWO: Count=2 (PC 0x3008 at head), Flush=1 with a concurrent offer -> next cycle Count=0, OutValid=0, OutData=0, offer dropped; OutPC=0x3008 with the macro defined, 0 without.
REQ-035 SHALL cover reset mid-operation: Count=2, Reset=1 together with Flush=1 and an offer -> next cycle all outputs 0, InReady=1, OutPC=0 in both builds.
REQ-036 SHALL cover ONE-state replace: Count=1, in&&out in the same cycle -> Count stays 1 and head equals the new offer.
